modq_prod_gen: RTL and testbench
================================

// Module: modq_prod_gen
// PURPOSE
// - Producer side of the 50-bit product stream consumed by the mod-q (q=33292289=2^25-2^18+1) reducer.
// - Accepts operand pairs (a,b) with a valid/ready handshake, forms a*b in a pipelined multiplier,
//   and buffers results in a small FIFO so downstream backpressure never drops a product.
// - Tags each product with a coefficient index and a last-of-polynomial marker for NTT/pointwise passes.
// PARAMETERS
// - Q          33292289  modulus; used only by the range check
// - MUL_STAGES 2         multiplier pipeline depth in cycles (>=1)
// - DEPTH      4         output FIFO entries (power of 2, >= MUL_STAGES+1)
// - N_COEF     256       coefficients per polynomial; sets the prod_last period
// PORTS
// - clk        in   1   clock
// - rst        in   1   reset, asynchronous, active-low
// - in_valid   in   1   operand pair valid
// - in_ready   out  1   block can accept an operand pair this cycle
// - in_a       in   25  operand a, expected in [0,Q)
// - in_b       in   25  operand b, expected in [0,Q)
// - prod_valid out  1   FIFO head valid
// - prod_ready in   1   downstream accepts head
// - prod       out  50  a*b, unsigned, full width, not reduced
// - prod_idx   out  8   coefficient index of the head, width clog2(N_COEF)
// - prod_last  out  1   head is index N_COEF-1
// - err        out  1   sticky operand range error (MODQ_RANGE_CHECK_EN only; else tied 0)
// BEHAVIOUR
// - Reset (rst=0, async) clears pipeline valids, FIFO pointers, counters and err.
//   prod_valid=0, prod=0, prod_idx=0, prod_last=0. in_ready=1 one cycle after reset is released.
// - An operand pair is accepted on a cycle with in_valid & in_ready.
//   Index counter idx_in increments per accept and wraps N_COEF-1 -> 0.
// - Credits: inflight = valid stages in the multiplier, occ = FIFO occupancy.
//   in_ready = (inflight + occ) < DEPTH, registered-free combinational, no dependence on in_valid.
//   The FIFO therefore never overflows. A write to a full FIFO is an assertion failure.
// - Pipeline: MUL_STAGES register stages carry {valid, a*b, idx}. Stage 1 registers operands
//   and the partial product; the final stage writes the FIFO.
// - Latency: accept at cycle t -> prod_valid=1 with that product at t+MUL_STAGES+1, FIFO empty.
// - FIFO head is registered. A pop occurs on prod_valid & prod_ready.
//   Simultaneous push and pop keeps occ unchanged.
//   A pop from a 1-entry FIFO with a simultaneous push shows the new head next cycle, with no bubble.
// - While prod_valid=1 and prod_ready=0: prod, prod_idx and prod_last hold stable.
// - Order: products leave in acceptance order. Throughput is 1 per cycle when prod_ready=1.
// - Arithmetic: 25x25 unsigned -> 50 bits, no truncation. (Q-1)^2 = 0x3F01000000000 fits.
// - Mid-stream reset discards all in-flight and buffered products. Indices restart at 0.
// CONFIGURATION
// - Macro MODQ_RANGE_CHECK_EN.
// - Defined: on accept, if in_a>=Q or in_b>=Q, err sets 1 and stays set until reset.
//   The product is still computed and forwarded unchanged.
// - Undefined: no comparators are built, and err is a constant 0.
// STRUCTURE
// - Shared package/include modq_pkg: localparams Q, Q_BITS=25, PROD_BITS=50, N_COEF,
//   IDX_BITS=$clog2(N_COEF). The reducer uses the same constants.
// - One sub-module: modq_sync_fifo, a parameterised synchronous FIFO with width PROD_BITS+IDX_BITS+1,
//   depth DEPTH, full/empty/occ outputs.
// - The multiplier pipeline, credit logic and index counter sit in the top module.
// TESTING
// - Reset + single op: a=3, b=5, prod_ready=1.
//   -> prod=15, prod_idx=0, prod_valid exactly MUL_STAGES+1 cycles after accept, for 1 cycle.
// - Max operands: a=b=33292288.
//   -> prod=0x3F01000000000, and the reducer fed from it returns 1.
// - Backpressure: prod_ready=0, in_valid=1 held, random operands.
//   -> exactly DEPTH accepts, then in_ready=0. Release prod_ready: all DEPTH products in order, none lost.
// - Streaming: 256 back-to-back ops, prod_ready=1.
//   -> 1 product/cycle, prod_last only on idx 255, op 257 has idx 0.
// - Random prod_ready toggle, 10k ops.
//   -> outputs equal a*b scoreboard in order. Head stable while stalled.
// - MODQ_RANGE_CHECK_EN: a=33292289, b=2.
//   -> err=1 from the next cycle and sticky, prod=66584578. Without the macro, err stays 0.
//   Async reset mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/modq_pkg.sv
// ---------------------------------------------------------------------------
// modq_pkg
// Constants shared by the mod-q product generator and the mod-q reducer.
//   q = 33292289 = 2^25 - 2^18 + 1
// Contents:
//   Q, Q_BITS, PROD_BITS  : modulus and operand/product widths
//   N_COEF, IDX_BITS      : coefficients per polynomial and index width
//   IDX_MAX               : index that carries the last-of-polynomial marker
//   B_LO_BITS             : split point of operand b for the partial products
//   in_range()            : operand < Q test used by the optional range check
// ---------------------------------------------------------------------------
package modq_pkg;

  localparam int unsigned Q         = 33292289;
  localparam int          Q_BITS    = 25;
  localparam int          PROD_BITS = 2 * Q_BITS;
  localparam int          N_COEF    = 256;
  localparam int          IDX_BITS  = $clog2(N_COEF);

  localparam logic [IDX_BITS-1:0] IDX_MAX = IDX_BITS'(N_COEF - 1);

  // b is split into a low and a high slice; stage 1 holds a*b_lo and a*b_hi.
  localparam int B_LO_BITS = 13;
  localparam int B_HI_BITS = Q_BITS - B_LO_BITS;

  function automatic logic in_range(input logic [Q_BITS-1:0] x);
    return (32'(x) < Q);
  endfunction

endpackage

// File: rtl/modq_sync_fifo.sv
// ---------------------------------------------------------------------------
// modq_sync_fifo
// Synchronous FIFO with a registered head. The head register is part of the
// occupancy: occ = head valid + entries waiting in the body storage.
// A write into an empty FIFO goes straight into the head register, so the
// data is visible on the cycle after the write. A pop with a simultaneous
// write on a 1-entry FIFO reloads the head with the new data (no bubble).
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   i_wr           write strobe (caller guarantees not full)
//   i_wr_data      write data
//   i_rd           consumer ready; a pop happens on i_rd & !o_empty
//   o_rd_data      head data (registered, stable while not popped)
//   o_empty        head not valid
//   o_full         occ == DEPTH
//   o_occ          number of stored entries including the head
// Parameters: WIDTH data width, DEPTH entries (power of 2, >= 2)
// ---------------------------------------------------------------------------
module modq_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_rd,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_occ
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [PTR_BITS-1:0] r_wr_ptr;
  logic [PTR_BITS-1:0] r_rd_ptr;
  logic [CNT_BITS-1:0] r_body_cnt;
  logic [WIDTH-1:0]    r_head;
  logic                r_head_vld;

  logic w_pop;
  logic w_head_free;
  logic w_body_empty;
  logic w_load_body;
  logic w_bypass;
  logic w_body_push;

  assign w_pop        = r_head_vld & i_rd;
  assign w_head_free  = ~r_head_vld | w_pop;
  assign w_body_empty = (r_body_cnt == '0);
  // Older body entries always refill the head before new data, keeping order.
  assign w_load_body  = w_head_free & ~w_body_empty;
  assign w_bypass     = w_head_free & w_body_empty & i_wr;
  assign w_body_push  = i_wr & ~w_bypass;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head_vld <= 1'b0;
      r_head     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_body_cnt <= '0;
    end else begin
      if (w_head_free) begin
        r_head_vld <= w_load_body | w_bypass;
      end
      if (w_load_body) begin
        r_head <= r_mem[r_rd_ptr];
      end else if (w_bypass) begin
        r_head <= i_wr_data;
      end
      if (w_body_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_load_body) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_body_cnt <= r_body_cnt + CNT_BITS'(w_body_push) - CNT_BITS'(w_load_body);
    end
  end

  // Body storage carries no reset; only pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (w_body_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_head;
  assign o_empty   = ~r_head_vld;
  assign o_occ     = r_body_cnt + CNT_BITS'(r_head_vld);
  assign o_full    = (o_occ == CNT_BITS'(DEPTH));

endmodule

// File: rtl/modq_prod_gen.sv
// ---------------------------------------------------------------------------
// modq_prod_gen
// Producer of the 50-bit product stream feeding the mod-q reducer.
// Operand pairs (a,b) are multiplied in a MUL_STAGES-deep pipeline and the
// full-width products, tagged with a coefficient index and a last marker,
// are buffered in a DEPTH-entry FIFO.
//
// Handshake (both ports): a transfer happens on a cycle where valid and ready
// are both 1. A source holding valid=1 keeps its payload stable until the
// transfer; ready never depends on valid in the same cycle.
//
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   in_valid     operand pair valid
//   in_ready     an operand pair can be accepted this cycle
//   in_a, in_b   25-bit operands, expected in [0,Q)
//   prod_valid   FIFO head valid
//   prod_ready   downstream accepts the head
//   prod         a*b, 50 bits, not reduced
//   prod_idx     coefficient index of the head
//   prod_last    head carries index N_COEF-1
//   err          sticky operand range error
// Parameters: MUL_STAGES (>=1), DEPTH (power of 2, >= MUL_STAGES+1)
// Build option: define MODQ_RANGE_CHECK_EN to build the operand range check;
// without it err is a constant 0.
// ---------------------------------------------------------------------------
module modq_prod_gen
  import modq_pkg::*;
#(
  parameter int MUL_STAGES = 2,
  parameter int DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [Q_BITS-1:0]    in_a,
  input  logic [Q_BITS-1:0]    in_b,
  output logic                 prod_valid,
  input  logic                 prod_ready,
  output logic [PROD_BITS-1:0] prod,
  output logic [IDX_BITS-1:0]  prod_idx,
  output logic                 prod_last,
  output logic                 err
);

  localparam int CNT_BITS  = $clog2(DEPTH) + 1;
  localparam int FIFO_W    = PROD_BITS + IDX_BITS + 1;
  localparam int PLO_BITS  = Q_BITS + B_LO_BITS;
  localparam int PHI_BITS  = Q_BITS + B_HI_BITS;

  logic                  w_accept;
  logic                  w_last_in;
  logic                  r_run;
  logic [IDX_BITS-1:0]   r_idx_in;

  logic [MUL_STAGES-1:0] r_vld;
  logic [MUL_STAGES-1:0] r_slast;
  logic [IDX_BITS-1:0]   r_sidx [MUL_STAGES];
  logic [PLO_BITS-1:0]   r_plo;
  logic [PHI_BITS-1:0]   r_phi;
  logic [PROD_BITS-1:0]  w_sum;
  logic [PROD_BITS-1:0]  w_fin_prod;

  logic [CNT_BITS-1:0]   w_inflight;
  logic [CNT_BITS-1:0]   w_occ;
  logic [CNT_BITS:0]     w_used;
  logic                  w_fifo_wr;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [FIFO_W-1:0]     w_fifo_wdata;
  logic [FIFO_W-1:0]     w_fifo_rdata;

  assign w_accept  = in_valid & in_ready;
  assign w_last_in = (r_idx_in == IDX_MAX);

  // in_ready stays low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx_in <= '0;
    end else if (w_accept) begin
      r_idx_in <= w_last_in ? '0 : r_idx_in + 1'b1;
    end
  end

  // Stage valids: the only pipeline state that needs a reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_accept;
      for (int k = 1; k < MUL_STAGES; k++) begin
        r_vld[k] <= r_vld[k-1];
      end
    end
  end

  // Stage 1 registers the two partial products a*b_lo and a*b_hi along with
  // the tag; later stages only move the tag along.
  always_ff @(posedge clk) begin
    r_plo      <= {{B_LO_BITS{1'b0}}, in_a} * {{Q_BITS{1'b0}}, in_b[B_LO_BITS-1:0]};
    r_phi      <= {{B_HI_BITS{1'b0}}, in_a} * {{Q_BITS{1'b0}}, in_b[Q_BITS-1:B_LO_BITS]};
    r_sidx[0]  <= r_idx_in;
    r_slast[0] <= w_last_in;
    for (int k = 1; k < MUL_STAGES; k++) begin
      r_sidx[k]  <= r_sidx[k-1];
      r_slast[k] <= r_slast[k-1];
    end
  end

  assign w_sum = {{(PROD_BITS-PLO_BITS){1'b0}}, r_plo} + {r_phi, {B_LO_BITS{1'b0}}};

  // With a single stage the partial-product sum feeds the FIFO directly;
  // otherwise stage 2 registers the sum and any further stages delay it.
  if (MUL_STAGES == 1) begin : g_mul_one
    assign w_fin_prod = w_sum;
  end else begin : g_mul_multi
    logic [PROD_BITS-1:0] r_prod [1:MUL_STAGES-1];
    always_ff @(posedge clk) begin
      r_prod[1] <= w_sum;
      for (int k = 2; k < MUL_STAGES; k++) begin
        r_prod[k] <= r_prod[k-1];
      end
    end
    assign w_fin_prod = r_prod[MUL_STAGES-1];
  end

  // Credits: every accepted pair owns a FIFO slot from accept until pop, so
  // the FIFO can never be written while full.
  always_comb begin
    w_inflight = '0;
    for (int k = 0; k < MUL_STAGES; k++) begin
      w_inflight = w_inflight + CNT_BITS'(r_vld[k]);
    end
  end

  assign w_used   = {1'b0, w_inflight} + {1'b0, w_occ};
  assign in_ready = r_run & (w_used < (CNT_BITS+1)'(DEPTH));

  assign w_fifo_wr    = r_vld[MUL_STAGES-1];
  assign w_fifo_wdata = {w_fin_prod, r_sidx[MUL_STAGES-1], r_slast[MUL_STAGES-1]};

  modq_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr      (w_fifo_wr),
    .i_wr_data (w_fifo_wdata),
    .i_rd      (prod_ready),
    .o_rd_data (w_fifo_rdata),
    .o_empty   (w_fifo_empty),
    .o_full    (w_fifo_full),
    .o_occ     (w_occ)
  );

  assign prod_valid = ~w_fifo_empty;
  assign {prod, prod_idx, prod_last} = w_fifo_rdata;

  a_fifo_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    !(w_fifo_wr && w_fifo_full));

`ifdef MODQ_RANGE_CHECK_EN
  // Out-of-range operands are still multiplied and forwarded; only flagged.
  logic r_err;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_accept && (!in_range(in_a) || !in_range(in_b))) begin
      r_err <= 1'b1;
    end
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_modq_prod_gen.sv
module tb_modq_prod_gen;

  localparam int MUL_STAGES = 2;
  localparam int DEPTH      = 4;
  localparam longint unsigned QM = 33292289;
  localparam int NC = 256;
  localparam int W  = 59;  // {prod[49:0], idx[7:0], last}
`ifdef MODQ_RANGE_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] in_a;
  logic [24:0] in_b;
  logic        prod_valid;
  logic        prod_ready;
  logic [49:0] prod;
  logic [7:0]  prod_idx;
  logic        prod_last;
  logic        err;

  modq_prod_gen #(
    .MUL_STAGES (MUL_STAGES),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod       (prod),
    .prod_idx   (prod_idx),
    .prod_last  (prod_last),
    .err        (err)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: expected products in acceptance order
  logic [W-1:0] exp_q[$];
  int           idx_m = 0;
  int           n_pop = 0;
  int           n_last = 0;
  logic [7:0]   last_pop_idx = '0;
  logic         stall_v = 1'b0;
  logic [W-1:0] stall_data = '0;

  always @(negedge clk) begin
    logic [63:0] pa;
    logic [W-1:0] item;
    if (!rst) begin
      exp_q.delete();
      idx_m   = 0;
      stall_v = 1'b0;
    end else begin
      if (stall_v)
        check("head_stable", {prod_valid, prod, prod_idx, prod_last}, {1'b1, stall_data});
      if (prod_valid && prod_ready) begin
        item = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        check("prod_stream", {prod, prod_idx, prod_last}, item);
        n_pop++;
        if (prod_last) n_last++;
        last_pop_idx = prod_idx;
      end
      stall_v    = prod_valid && !prod_ready;
      stall_data = {prod, prod_idx, prod_last};
      if (in_valid && in_ready) begin
        pa = 64'(in_a) * 64'(in_b);
        exp_q.push_back({pa[49:0], 8'(idx_m), (idx_m == NC - 1)});
        idx_m = (idx_m + 1) % NC;
      end
    end
  end

  // driver tasks
  int send_cycles = 0;

  task automatic send(input logic [24:0] a, input logic [24:0] b);
    int  n = 0;
    logic acc = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    send_cycles = n;
    check("send_accept", acc, 1'b1);
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || prod_valid) && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [24:0] rnd_op();
    return 25'($urandom_range(32'(QM - 1), 0));
  endfunction

  initial begin
    int cyc;
    int acc;
    int p0;
    int l0;
    logic done;

    rst        = 1'b0;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    prod_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_prod_valid", prod_valid, 0);
    check("rst_prod", prod, 0);
    check("rst_prod_idx", prod_idx, 0);
    check("rst_prod_last", prod_last, 0);
    check("rst_err", err, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", in_ready, 1);

    // single op: latency and one-cycle valid
    send(25'd3, 25'd5);
    in_valid = 1'b0;
    cyc = 0;
    while (!prod_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("single_latency", cyc, MUL_STAGES);
    check("single_prod", prod, 15);
    check("single_idx", prod_idx, 0);
    @(posedge clk);
    #1;
    check("single_valid_1cyc", prod_valid, 0);

    // max operands
    send(25'(QM - 1), 25'(QM - 1));
    in_valid = 1'b0;
    cyc = 0;
    while (!prod_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("max_prod", prod, 64'h3F01000000000);
    check("max_reduced", 64'(prod) % QM, 1);
    wait_drain(50);

    // backpressure: exactly DEPTH accepts then in_ready low
    prod_ready = 1'b0;
    acc = 0;
    in_valid = 1'b1;
    in_a = rnd_op();
    in_b = rnd_op();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk);
      #1;
      if (in_ready || i == 0) begin
        in_a = rnd_op();
        in_b = rnd_op();
      end
    end
    check("bp_accepts", acc, DEPTH);
    check("bp_in_ready", in_ready, 0);
    check("bp_prod_valid", prod_valid, 1);
    in_valid = 1'b0;
    p0 = n_pop;
    prod_ready = 1'b1;
    wait_drain(50);
    check("bp_pops", n_pop - p0, DEPTH);

    // streaming 257 back-to-back ops from index 0
    do_reset();
    prod_ready = 1'b1;
    l0 = n_last;
    for (int i = 0; i < NC + 1; i++) begin
      send(rnd_op(), rnd_op());
      if (i > 0) check("stream_rate", send_cycles, 1);
    end
    in_valid = 1'b0;
    wait_drain(50);
    check("stream_last_cnt", n_last - l0, 1);
    check("stream_257_idx", last_pop_idx, 0);

    // operand range check
    send(25'(QM), 25'd2);
    in_valid = 1'b0;
    check("err_next_cycle", err, EXP_ERR);
    repeat (5) @(posedge clk);
    #1;
    check("err_sticky", err, EXP_ERR);
    wait_drain(50);

    // asynchronous reset in the middle of a burst
    prod_ready = 1'b0;
    in_valid = 1'b1;
    in_a = rnd_op();
    in_b = rnd_op();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_prod_valid", prod_valid, 0);
    check("arst_prod", prod, 0);
    check("arst_idx", prod_idx, 0);
    check("arst_last", prod_last, 0);
    check("arst_err", err, 0);
    check("arst_in_ready", in_ready, 0);
    in_valid = 1'b0;
    prod_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("arst_flushed", prod_valid, 0);

    // random prod_ready, 10k ops
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(3, 0) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          send(rnd_op(), rnd_op());
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          prod_ready = 1'($urandom_range(1, 0));
        end
      end
    join
    prod_ready = 1'b1;
    wait_drain(100);
    check("rand_err_clear", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
